// File: rtl/t02_load_store_unit.sv
// ============================================================================
// Module   : t02_load_store_unit
// Brief    : Multi-cycle load/store unit: one byte-laned bus access per memory
//            instruction, stalling the core, with extended load write-back.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module t02_load_store_unit (
  input  logic        clk,
  input  logic        nRST,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  input  logic [31:0] bus_rdata,
  input  logic        bus_busy,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  output logic        bus_read,
  output logic        bus_write,
  output logic        stall,
  output logic        reg_write,
  output logic [4:0]  write_index,
  output logic [31:0] write_data,
  output logic        mem_fault
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQUEST = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_addr;
  logic [2:0]  r_funct3;
  logic [4:0]  r_rd;
  logic [31:0] r_wdata;
  logic        r_is_load;
  logic [31:0] r_rdata;

  logic        w_req, w_legal, w_aligned, w_accept;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_val;

  // Gating with nRST keeps every output at zero while reset is held.
  assign w_req = nRST & (mem_read | mem_write);

  always_comb begin
    w_legal = 1'b0;
    if (mem_read) begin
      w_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                (funct3 == 3'b100) || (funct3 == 3'b101);
    end else begin
      w_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    end
    w_aligned = 1'b1;
    if (funct3[1:0] == 2'b01) w_aligned = ~addr[0];
    if (funct3[1:0] == 2'b10) w_aligned = (addr[1:0] == 2'b00);
  end

  assign w_accept = (r_state == IDLE) && w_req && w_legal && w_aligned;

  assign w_byte = r_rdata[{r_addr[1:0], 3'b000} +: 8];
  assign w_half = r_rdata[{r_addr[1], 4'b0000} +: 16];

  always_comb begin
    w_load_val = 32'd0;
    case (r_funct3)
      3'b000:  w_load_val = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
      3'b010:  w_load_val = r_rdata;
      3'b100:  w_load_val = {24'd0, w_byte};
      3'b101:  w_load_val = {16'd0, w_half};
      default: w_load_val = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state   <= IDLE;
      r_addr    <= 32'd0;
      r_funct3  <= 3'd0;
      r_rd      <= 5'd0;
      r_wdata   <= 32'd0;
      r_is_load <= 1'b0;
      r_rdata   <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr    <= addr;
        r_funct3  <= funct3;
        r_rd      <= rd;
        r_wdata   <= store_data;
        r_is_load <= mem_read;
      end
      if ((r_state == WAIT) && !bus_busy && r_is_load) r_rdata <= bus_rdata;
    end
  end

  always_comb begin
    w_next      = r_state;
    bus_addr    = 32'd0;
    bus_wdata   = 32'd0;
    bus_sel     = 4'd0;
    bus_read    = 1'b0;
    bus_write   = 1'b0;
    stall       = 1'b0;
    reg_write   = 1'b0;
    write_index = 5'd0;
    write_data  = 32'd0;
    mem_fault   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          stall  = 1'b1;
          w_next = REQUEST;
        end else if (w_req) begin
          mem_fault = 1'b1;
        end
      end
      REQUEST, WAIT: begin
        stall    = 1'b1;
        bus_addr = {r_addr[31:2], 2'b00};
        if (r_is_load) begin
          bus_sel = 4'b1111;
        end else begin
          case (r_funct3[1:0])
            2'b00: begin
              bus_sel   = 4'b0001 << r_addr[1:0];
              bus_wdata = {4{r_wdata[7:0]}};
            end
            2'b01: begin
              bus_sel   = 4'b0011 << {r_addr[1], 1'b0};
              bus_wdata = {2{r_wdata[15:0]}};
            end
            default: begin
              bus_sel   = 4'b1111;
              bus_wdata = r_wdata;
            end
          endcase
        end
        if (r_state == REQUEST) begin
          bus_read  = r_is_load;
          bus_write = ~r_is_load;
          w_next    = WAIT;
        end else if (!bus_busy) begin
          w_next = DONE;
        end
      end
      DONE: begin
        if (r_is_load && (r_rd != 5'd0)) begin
          reg_write   = 1'b1;
          write_index = r_rd;
          write_data  = w_load_val;
        end
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_t02_load_store_unit.sv
// ============================================================================
// Module   : tb_t02_load_store_unit
// Brief    : Directed + randomized bench for t02_load_store_unit against an
//            arithmetic reference model of the load/store rules.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_t02_load_store_unit;

  logic        clk = 1'b0;
  logic        nRST = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0, store_data = 32'd0, bus_rdata = 32'd0;
  logic [4:0]  rd = 5'd0;
  logic        bus_busy = 1'b0;
  logic [31:0] bus_addr, bus_wdata, write_data;
  logic [3:0]  bus_sel;
  logic        bus_read, bus_write, stall, reg_write, mem_fault;
  logic [4:0]  write_index;

  int n_tests = 0;
  int n_fail  = 0;

  t02_load_store_unit dut (
    .clk(clk), .nRST(nRST), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .store_data(store_data), .rd(rd),
    .bus_rdata(bus_rdata), .bus_busy(bus_busy), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_sel(bus_sel), .bus_read(bus_read),
    .bus_write(bus_write), .stall(stall), .reg_write(reg_write),
    .write_index(write_index), .write_data(write_data), .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: plain arithmetic on access size and byte offset.
  function automatic bit ref_fault(input bit ld, input logic [2:0] f3, input logic [31:0] a);
    int size;
    bit legal;
    legal = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
    size  = 1 << (f3 % 4);
    return !legal || ((a % size) != 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] d);
    longint unsigned b, h;
    b = (d >> (8 * (a % 4))) % 256;
    h = (d >> (8 * (a % 4))) % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? 32'(b + 32'hFFFFFF00) : 32'(b);
      3'd1:    return (h >= 32768) ? 32'(h + 32'hFFFF0000) : 32'(h);
      3'd4:    return 32'(b);
      3'd5:    return 32'(h);
      default: return d;
    endcase
  endfunction

  task automatic run_op(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [4:0] r, input logic [31:0] rdat,
                        input int busy_n);
    bit          is_load, flt, exp_rw;
    int          size;
    logic [31:0] exp_sel, exp_wd, exp_addr;
    is_load  = ld;
    flt      = ref_fault(is_load, f3, a);
    size     = 1 << (f3 % 4);
    exp_addr = a - (a % 4);
    exp_sel  = is_load ? 32'hF : 32'(((1 << size) - 1) << (a % 4));
    exp_wd   = (size == 1) ? (sd % 256) * 32'h01010101 :
               (size == 2) ? (sd % 65536) * 32'h00010001 : sd;
    exp_rw   = is_load && (r != 0);

    @(posedge clk); #1;
    mem_read = ld; mem_write = st; funct3 = f3; addr = a; store_data = sd; rd = r;
    bus_busy = 1'($urandom);
    @(negedge clk);
    check("fault", 32'(mem_fault), 32'(flt));
    check("stall_accept", 32'(stall), 32'(!flt));
    check("strobes_idle", {bus_read, bus_write}, 32'd0);
    if (flt) begin
      @(posedge clk); #1;
      mem_read = 0; mem_write = 0;
      @(negedge clk);
      check("fault_once", 32'(mem_fault), 32'd0);
      check("fault_no_rw", 32'(reg_write), 32'd0);
      check("fault_no_stall", 32'(stall), 32'd0);
      return;
    end
    @(posedge clk); #1;
    mem_read = 0; mem_write = 0; addr = $urandom; store_data = $urandom; rd = 5'($urandom);
    bus_busy = 1'($urandom);
    @(negedge clk);
    check("req_read", 32'(bus_read), 32'(is_load));
    check("req_write", 32'(bus_write), 32'(!is_load));
    check("req_addr", bus_addr, exp_addr);
    check("req_sel", 32'(bus_sel), exp_sel);
    if (!is_load) check("req_wdata", bus_wdata, exp_wd);
    check("req_stall", 32'(stall), 32'd1);
    for (int i = 0; i < busy_n; i++) begin
      @(posedge clk); #1;
      bus_busy = 1'b1; bus_rdata = $urandom;
      @(negedge clk);
      check("wait_strobe", {bus_read, bus_write}, 32'd0);
      check("wait_stall", 32'(stall), 32'd1);
      check("wait_addr", bus_addr, exp_addr);
      check("wait_rw", 32'(reg_write), 32'd0);
    end
    @(posedge clk); #1;
    bus_busy = 1'b0; bus_rdata = rdat;
    @(negedge clk);
    check("wait_last_stall", 32'(stall), 32'd1);
    check("wait_last_sel", 32'(bus_sel), exp_sel);
    @(posedge clk); #1;
    bus_busy = 1'($urandom); bus_rdata = $urandom;
    @(negedge clk);
    check("done_stall", 32'(stall), 32'd0);
    check("done_rw", 32'(reg_write), 32'(exp_rw));
    check("done_sel", 32'(bus_sel), 32'd0);
    if (exp_rw) begin
      check("done_idx", 32'(write_index), 32'(r));
      check("done_data", write_data, ref_load(f3, a, rdat));
    end
  endtask

  initial begin
    #2;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_outs", {bus_read, bus_write, reg_write, mem_fault, bus_sel}, 32'd0);
    check("rst_addr", bus_addr, 32'd0);
    @(posedge clk); #1 nRST = 1'b1;

    run_op(1, 0, 3'b010, 32'h100, 32'h0, 5'd5, 32'hDEADBEEF, 0);
    run_op(1, 0, 3'b000, 32'h103, 32'h0, 5'd7, 32'h80FF0000, 3);
    run_op(1, 0, 3'b100, 32'h103, 32'h0, 5'd7, 32'h80FF0000, 3);
    run_op(0, 1, 3'b000, 32'h202, 32'h12345678, 5'd3, 32'h0, 0);
    run_op(0, 1, 3'b001, 32'h202, 32'h12345678, 5'd3, 32'h0, 1);
    run_op(1, 0, 3'b010, 32'h102, 32'h0, 5'd4, 32'h0, 0);
    run_op(1, 0, 3'b011, 32'h100, 32'h0, 5'd4, 32'h0, 0);
    run_op(1, 0, 3'b010, 32'h100, 32'h0, 5'd0, 32'h11223344, 0);
    run_op(1, 1, 3'b001, 32'h302, 32'h0, 5'd9, 32'h8001ABCD, 2);

    // Reset asserted mid-transaction, while the bus is still busy.
    @(posedge clk); #1;
    mem_read = 1; funct3 = 3'b010; addr = 32'h400; rd = 5'd6;
    @(posedge clk); #1 mem_read = 0;
    @(posedge clk); #1 bus_busy = 1'b1;
    @(negedge clk);
    check("pre_rst_stall", 32'(stall), 32'd1);
    #1 nRST = 1'b0;
    #1;
    check("arst_stall", 32'(stall), 32'd0);
    check("arst_sel", 32'(bus_sel), 32'd0);
    check("arst_addr", bus_addr, 32'd0);
    @(posedge clk); #1 nRST = 1'b1; bus_busy = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 32'(stall), 32'd0);
    run_op(1, 0, 3'b010, 32'h404, 32'h0, 5'd6, 32'hCAFEF00D, 1);

    for (int k = 0; k < 300; k++) begin
      logic [31:0] a;
      bit ld;
      ld = 1'($urandom);
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = ($urandom_range(0, 1) != 0) ? 2'b00 : a[1:0] & 2'b10;
      run_op(ld, !ld || 1'($urandom), 3'($urandom), a, $urandom, 5'($urandom),
             $urandom, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
